// File: rtl/rv32m_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rv32m_sequencer_pkg
// Shared definitions for the RV32M execute-stage sequencer:
//   - funct3 codes of the M-extension operations
//   - sequencer state encoding
//   - divide special-case constants
//   - small decode helpers for operand signedness
// -----------------------------------------------------------------------------
package rv32m_sequencer_pkg;

  localparam int XLEN = 32;

  // funct3 of the M-extension opcodes.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } m_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  // DIV and REM are signed; DIVU and REMU are not (funct3 bit 0 set).
  function automatic logic is_signed_div(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  // Within the divide group, bit 1 selects the remainder.
  function automatic logic is_rem_op(input logic [2:0] op);
    return op[1];
  endfunction

  // Multiplicand is signed for MULH and MULHSU, multiplier only for MULH.
  function automatic logic mul_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic mul_b_signed(input logic [2:0] op);
    return op == OP_MULH;
  endfunction

endpackage

// File: rtl/rv32m_div_core.sv
// -----------------------------------------------------------------------------
// rv32m_div_core
// Unsigned restoring radix-2 divider datapath. LOAD captures the dividend into
// the quotient register, clears the partial remainder and holds the divisor.
// Each STEP shifts one dividend bit into the partial remainder and develops
// one quotient bit. After WIDTH steps Q holds the quotient and R the remainder.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   LOAD            start a new division (has priority over STEP)
//   STEP            perform one shift-subtract iteration
//   dividend        unsigned dividend, sampled on LOAD
//   divisor         unsigned divisor, sampled on LOAD (must be non-zero)
//   Q, R            quotient / partial remainder registers
// -----------------------------------------------------------------------------
module rv32m_div_core
  import rv32m_sequencer_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic             STEP,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             fits;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the trial difference's top bit is a clean borrow.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dsr_q};
    fits      = ~trial[WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (LOAD) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (STEP) begin
      quo_q <= {quo_q[WIDTH-2:0], fits};
      rem_q <= fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    end
  end

  assign Q = quo_q;
  assign R = rem_q;

endmodule

// File: rtl/rv32m_sequencer.sv
// -----------------------------------------------------------------------------
// rv32m_sequencer
// Multi-cycle RV32M controller for the execute stage. Accepts one operation
// at a time while idle, runs it on a MUL_LAT-deep multiplier pipeline or the
// iterative divider, and presents a registered result with READY until EX
// releases it (STALL low). Divide special cases and a repeat of the previous
// division's operands complete without iterating. FLUSH aborts at any time.
//
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   START        operation request, sampled only in IDLE
//   M_CNT        funct3 of the operation
//   RS1, RS2     operands, sampled on the accept edge
//   STALL        EX frozen: hold the result in DONE
//   FLUSH        abort; return to IDLE on the next edge
//   OUT          registered result, valid while READY=1
//   READY        result valid
//   BUSY         sequencer not idle
// -----------------------------------------------------------------------------
module rv32m_sequencer
  import rv32m_sequencer_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_BITS = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic [2:0]      M_CNT,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  input  logic            STALL,
  input  logic            FLUSH,
  output logic [XLEN-1:0] OUT,
  output logic            READY,
  output logic            BUSY
);

  localparam int CNT_W = $clog2(DIV_BITS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Operation latched on the accept edge.
  logic [2:0]        op_q;
  logic [XLEN-1:0]   op_a_q, op_b_q;

  logic [XLEN-1:0]   out_q, out_d;
  logic              out_load;
  logic              ready_q;
  logic              accept;

  // Last completed (non-special) division.
  logic              last_valid_q;
  logic              last_signed_q;
  logic [XLEN-1:0]   last_a_q, last_b_q, last_quo_q, last_rem_q;
  logic              cache_wr;

  // Divider interface.
  logic              div_load, div_step;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN-1:0]   div_quo, div_rem;
  logic [XLEN-1:0]   fix_quo, fix_rem;
  logic              op_signed;

  // Multiplier.
  logic signed [2*XLEN-1:0] mul_a, mul_b, mul_full;
  logic [XLEN-1:0]          mul_sel;
  logic [XLEN-1:0]          mul_pipe [MUL_LAT];

  // Decode of the raw request, used only on the accept edge.
  logic in_signed, in_rem, in_div0, in_ovf, in_fused;

  always_comb begin
    in_signed = is_signed_div(M_CNT);
    in_rem    = is_rem_op(M_CNT);
    in_div0   = (RS2 == '0);
    in_ovf    = in_signed && (RS1 == INT_MIN) && (RS2 == ALL_ONES);
    in_fused  = last_valid_q && (RS1 == last_a_q) && (RS2 == last_b_q) &&
                (in_signed == last_signed_q);
    // Negating INT_MIN yields 0x80000000, which is the correct unsigned magnitude.
    abs_a     = (in_signed && RS1[XLEN-1]) ? -RS1 : RS1;
    abs_b     = (in_signed && RS2[XLEN-1]) ? -RS2 : RS2;
  end

  // Operands are width-extended to 64 bits (sign or zero per op) so a single
  // 64x64 modular product covers all four multiply flavours.
  always_comb begin
    mul_a    = {{XLEN{mul_a_signed(M_CNT) & RS1[XLEN-1]}}, RS1};
    mul_b    = {{XLEN{mul_b_signed(M_CNT) & RS2[XLEN-1]}}, RS2};
    mul_full = mul_a * mul_b;
    mul_sel  = (M_CNT == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
  end

  // Sign correction of the unsigned divider result.
  always_comb begin
    op_signed = is_signed_div(op_q);
    fix_quo   = (op_signed && (op_a_q[XLEN-1] ^ op_b_q[XLEN-1])) ? -div_quo : div_quo;
    fix_rem   = (op_signed && op_a_q[XLEN-1]) ? -div_rem : div_rem;
  end

  rv32m_div_core #(
    .WIDTH (XLEN)
  ) u_div_core (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .LOAD     (div_load),
    .STEP     (div_step),
    .dividend (abs_a),
    .divisor  (abs_b),
    .Q        (div_quo),
    .R        (div_rem)
  );

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    out_load = 1'b0;
    out_d    = out_q;
    cache_wr = 1'b0;

    if (FLUSH) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (START) begin
            accept = 1'b1;
            if (!M_CNT[2]) begin
              state_d = ST_MUL;
            end else if (in_div0) begin
              state_d  = ST_DONE;
              out_load = 1'b1;
              out_d    = in_rem ? RS1 : ALL_ONES;
            end else if (in_ovf) begin
              state_d  = ST_DONE;
              out_load = 1'b1;
              out_d    = in_rem ? '0 : INT_MIN;
            end else if (in_fused) begin
              state_d  = ST_DONE;
              out_load = 1'b1;
              out_d    = in_rem ? last_rem_q : last_quo_q;
            end else begin
              state_d  = ST_DIV;
              div_load = 1'b1;
            end
          end
        end

        // The product enters the pipe on the accept edge; after MUL_LAT edges
        // it sits in the last stage and is transferred to OUT.
        ST_MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            state_d  = ST_DONE;
            cnt_d    = '0;
            out_load = 1'b1;
            out_d    = mul_pipe[MUL_LAT-1];
          end
        end

        ST_DIV: begin
          div_step = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_BITS - 1)) begin
            state_d = ST_FIX;
            cnt_d   = '0;
          end
        end

        ST_FIX: begin
          state_d  = ST_DONE;
          out_load = 1'b1;
          out_d    = is_rem_op(op_q) ? fix_rem : fix_quo;
          cache_wr = 1'b1;
        end

        ST_DONE: begin
          if (!STALL) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      out_q         <= '0;
      ready_q       <= 1'b0;
      last_valid_q  <= 1'b0;
      last_signed_q <= 1'b0;
      last_a_q      <= '0;
      last_b_q      <= '0;
      last_quo_q    <= '0;
      last_rem_q    <= '0;
    end else begin
      if (accept) begin
        op_q   <= M_CNT;
        op_a_q <= RS1;
        op_b_q <= RS2;
      end
      if (out_load) out_q <= out_d;
      ready_q <= (state_d == ST_DONE);
      if (cache_wr) begin
        last_valid_q  <= 1'b1;
        last_signed_q <= op_signed;
        last_a_q      <= op_a_q;
        last_b_q      <= op_b_q;
        last_quo_q    <= fix_quo;
        last_rem_q    <= fix_rem;
      end
    end
  end

  // NOTE: the multiplier pipe is pure datapath; its contents are only consumed
  // MUL_LAT edges after an accept, so it needs no reset.
  always_ff @(posedge CLK) begin
    mul_pipe[0] <= mul_sel;
    for (int i = 1; i < MUL_LAT; i++) begin
      mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  assign OUT   = out_q;
  assign READY = ready_q;
  assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rv32m_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rv32m_sequencer
// Scoreboard bench: the driver pushes the expected result and latency of each
// accepted operation; a monitor pops and compares on every rising READY.
// Expected values come from a reference model using plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_rv32m_sequencer;
  import rv32m_sequencer_pkg::*;

  localparam int MUL_LAT  = 2;
  localparam int DIV_BITS = 32;
  localparam int DIV_LAT  = DIV_BITS + 2;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  M_CNT = 3'd0;
  logic [31:0] RS1   = '0;
  logic [31:0] RS2   = '0;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] OUT;
  logic        READY;
  logic        BUSY;

  rv32m_sequencer #(
    .MUL_LAT  (MUL_LAT),
    .DIV_BITS (DIV_BITS)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .M_CNT (M_CNT),
    .RS1   (RS1),
    .RS2   (RS2),
    .STALL (STALL),
    .FLUSH (FLUSH),
    .OUT   (OUT),
    .READY (READY),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  // Rising-edge count; read only on falling edges.
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int unsigned acc;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Reference-model memory of the last completed ordinary division.
  bit          m_valid = 1'b0;
  bit          m_signed;
  logic [31:0] m_a, m_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    logic [63:0] pu;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  // Latency from accept to READY; also records completed ordinary divisions.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sgn;
    if (op < 3'd4) return MUL_LAT + 1;
    sgn = (op == 3'd4) || (op == 3'd6);
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (m_valid && a == m_a && b == m_b && sgn == m_signed) return 1;
    m_valid  = 1'b1;
    m_signed = sgn;
    m_a      = a;
    m_b      = b;
    return DIV_LAT;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY !== 1'b0) fail_now("idle_timeout: BUSY still 1 after 100 cycles, required 0");
  endtask

  // Issue one operation, record its expectation, and wait for READY while
  // scrambling the request inputs (they must be ignored while busy).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    sb_t e;
    int  n;
    wait_idle();
    START = 1'b1;
    M_CNT = op;
    RS1   = a;
    RS2   = b;
    e.exp  = ref_calc(op, a, b);
    e.lat  = ref_latency(op, a, b);
    e.acc  = cyc + 1;
    e.name = name;
    sb_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    while (READY !== 1'b1 && n < 60) begin
      START = 1'($urandom_range(0, 1));
      M_CNT = 3'($urandom_range(0, 7));
      RS1   = $urandom;
      RS2   = $urandom;
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
    if (READY !== 1'b1) fail_now({name, " ready_timeout: READY=0 after 60 cycles, required 1"});
  endtask

  // Start a division that will be aborted; nothing is expected from it.
  task automatic start_untracked(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    wait_idle();
    START = 1'b1;
    M_CNT = op;
    RS1   = a;
    RS2   = b;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare on every rising READY.
  initial begin : monitor
    bit  ready_prev;
    sb_t e;
    ready_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (READY === 1'b1 && !ready_prev) begin
        if (sb_q.size() == 0) begin
          fail_now($sformatf("unexpected_ready: READY=1 OUT=0x%08h, required no result", OUT));
        end else begin
          e = sb_q.pop_front();
          check({e.name, " result"}, OUT, e.exp);
          check({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
      ready_prev = READY;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] a, b, pa, pb;
    logic [2:0]  op;

    repeat (2) @(negedge CLK);
    check("reset OUT", OUT, 32'h0);
    check("reset READY", 32'(READY), 32'h0);
    check("reset BUSY", 32'(BUSY), 32'h0);
    RST_N = 1'b1;
    @(negedge CLK);

    // MUL with the result held by STALL.
    STALL = 1'b1;
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("stall%0d READY", i), 32'(READY), 32'h1);
      check($sformatf("stall%0d OUT", i), OUT, ref_calc(3'd0, 32'd7, 32'hFFFF_FFFD));
    end
    STALL = 1'b0;
    @(negedge CLK);
    check("release READY", 32'(READY), 32'h0);
    check("release BUSY", 32'(BUSY), 32'h0);

    issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min");
    issue(OP_MULHU,  32'h8000_0000, 32'h8000_0000, "mulhu_min");
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");

    // Ordinary division followed by the fused remainder.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem_-7/2_fused");

    // Special cases.
    issue(OP_DIVU, 32'h1234, 32'h0, "divu_by0");
    issue(OP_REMU, 32'h1234, 32'h0, "remu_by0");
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Flush during iteration 10; the aborted division must not be cached.
    start_untracked(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush BUSY", 32'(BUSY), 32'h0);
    check("flush READY", 32'(READY), 32'h0);
    issue(OP_REMU, 32'd100, 32'd7, "remu_after_flush");

    // Random operations, sometimes repeating the previous operands as a divide.
    pa = 32'd1;
    pb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        a  = pa;
        b  = pb;
        op = 3'd4 + 3'($urandom_range(0, 3));
      end else begin
        a = pick();
        b = pick();
      end
      issue(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
      pa = a;
      pb = b;
    end

    // Asynchronous reset in the middle of a division.
    start_untracked(OP_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    m_valid = 1'b0;
    #1;
    check("async_rst BUSY", 32'(BUSY), 32'h0);
    check("async_rst READY", 32'(READY), 32'h0);
    check("async_rst OUT", OUT, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // FLUSH wins over START in IDLE.
    FLUSH = 1'b1;
    START = 1'b1;
    M_CNT = OP_MUL;
    RS1   = 32'd5;
    RS2   = 32'd6;
    @(negedge CLK);
    check("flush_start BUSY", 32'(BUSY), 32'h0);
    check("flush_start READY", 32'(READY), 32'h0);
    FLUSH = 1'b0;
    START = 1'b0;

    // Cache was cleared by reset: this is a full-length division.
    issue(OP_REMU, 32'd100, 32'd7, "remu_after_reset");
    issue(OP_DIVU, 32'd100, 32'd7, "divu_after_reset_fused");

    repeat (3) @(negedge CLK);
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32m_sequencer.md
Name: rv32m_sequencer

Overview:
Multi-cycle controller for the RV32M extension in the execute stage.
- Accepts one M-extension operation at a time from the EX stage.
- Sequences a fixed-latency pipelined multiplier and an iterative radix-2 divider.
- Resolves divide special cases without iterating, and reuses the previous division's quotient/remainder for a back-to-back DIV/REM pair.
- Drives READY so EX can hold the pipeline until the result is valid; aborts cleanly on pipeline flush.

Parameters:
MUL_LAT, 2, multiplier pipeline depth in cycles (1..4)
DIV_BITS, 32, dividend width = number of divide iterations

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  M-op request; level, sampled only in IDLE
M_CNT  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
RS1  in  32  operand 1 (multiplicand / dividend)
RS2  in  32  operand 2 (multiplier / divisor)
STALL  in  1  pipeline frozen; holds DONE
FLUSH  in  1  abort in-flight op
OUT  out  32  registered result, valid while READY=1
READY  out  1  result valid
BUSY  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, OUT=0, READY=0, BUSY=0, last_valid=0, counters=0. The reset is asynchronous and active-low.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, START=1 & FLUSH=0: latch M_CNT/RS1/RS2 (accept edge = cycle 0), then:
  - M_CNT<4 -> MUL; count MUL_LAT cycles -> DONE; READY first high in cycle MUL_LAT+1.
  - Divide special case (divisor 0, or signed DIV/REM with 0x80000000 / 0xFFFFFFFF) -> DONE directly; READY in cycle 1.
  - Fused case -> DONE directly; READY in cycle 1. Fused case = last_valid, and latched operands and signedness equal the last completed division.
  - Otherwise -> DIV.
- DIV: take absolute values for signed ops; one shift-subtract per cycle for DIV_BITS cycles, iteration counter 0..31; then FIX.
- FIX: one cycle. Apply signs: quotient negated if operand signs differ; remainder takes the dividend sign. Store quotient, remainder, operands, signedness; set last_valid=1. Then DONE. READY in cycle 34.
- Divide results:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = RS1.
  - Signed overflow: quotient 0x80000000, remainder 0.
  - Special cases do not update last_valid.
- Multiply results:
  - MUL: low 32 bits.
  - MULH: signed×signed high.
  - MULHSU: signed RS1 × unsigned RS2, high.
  - MULHU: unsigned high.
  - 64-bit product, width-extended before multiply.
- DONE: READY=1, OUT stable.
  - STALL=1: remain in DONE.
  - STALL=0: -> IDLE next cycle; READY drops.
  - START seen in that IDLE cycle is a new op; back-to-back issue costs one IDLE cycle.
- FLUSH=1 in any state: -> IDLE next edge, READY=0.
  - Aborted division does not touch last_valid or stored results.
  - FLUSH with START in IDLE: flush wins, op not accepted.
- START, M_CNT and operand changes outside IDLE are ignored.
- BUSY is combinational from state. READY is registered (set on entry to DONE).

Decomposition:
- Shared package (PipelineParams):
  - M_CNT funct3 codes.
  - State encodings for the five states.
  - Special-case constants 0x80000000 and 0xFFFFFFFF.
- One sub-module, rv32m_div_core: holds the partial remainder and quotient registers and performs one shift-subtract step per enable.
  - Ports: CLK, RST_N, LOAD, STEP, dividend, divisor, Q, R.
- The sequencer owns the FSM, counters, sign handling, the multiplier pipeline and the last-division cache.

Test Plan:
- MUL RS1=7 RS2=0xFFFFFFFD (-3), MUL_LAT=2 -> READY at cycle 3, OUT=0xFFFFFFEB; STALL=1 for 4 cycles holds OUT/READY; STALL=0 -> READY=0 next cycle.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV RS1=0xFFFFFFF9 (-7) RS2=2 -> READY at cycle 34, OUT=0xFFFFFFFD; immediately REM with same operands -> READY at cycle 1, OUT=0xFFFFFFFF (fused).
- DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each READY at cycle 1.
- DIVU 100/7 with FLUSH at iteration 10 -> IDLE next cycle, READY never asserts; then REMU 100/7 is not fused, READY at cycle 34, OUT=2.
- Assert RST_N=0 mid-DIV, asynchronously -> BUSY/READY/OUT=0 immediately, last_valid cleared; FLUSH+START same cycle in IDLE -> no accept, BUSY stays 0.
